// File: rtl/serdes_rx_aligner.sv
// Receive word aligner: bitslips the ISERDES until the training word repeats
// MATCH_COUNT times, then forwards masked data and counts training mismatches.
module serdes_rx_aligner #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h2C,
    parameter int unsigned MATCH_COUNT   = 16,
    parameter int unsigned BITSLIP_WAIT  = 4,
    parameter int unsigned MAX_SLIPS     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        train,
    input  logic        restart,
    output logic        bitslip,
    output logic        locked,
    output logic        failed,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic [15:0] err_cnt
);
    localparam logic [8:0] MASK_FULL  = (9'd1 << DATA_WIDTH) - 9'd1;
    localparam logic [7:0] MASK       = MASK_FULL[7:0];
    localparam logic [7:0] PATTERN    = TRAIN_PATTERN & MASK;
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] SLIP_LIMIT = 8'(MAX_SLIPS);
    localparam logic [3:0] WAIT_LAST  = 4'(BITSLIP_WAIT - 1);

    typedef enum logic [2:0] {SEARCH, SLIP, WAIT, LOCKED, FAIL} state_t;

    state_t     state;
    logic [7:0] match_cnt;
    logic [7:0] slip_cnt;
    logic [3:0] wait_cnt;
    logic [7:0] word;
    logic       hit;

    assign word = din & MASK;
    assign hit  = (word == PATTERN);

    always_ff @(posedge clk) begin
        // restart clears exactly what reset clears, so both share one branch
        if (rst || restart) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            wait_cnt   <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            failed     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err_cnt    <= '0;
        end else begin
            // NOTE: <= keeps every branch reading pre-edge state; blocking here would race.
            bitslip <= 1'b0;
            case (state)
                SEARCH: begin
                    if (hit) begin
                        match_cnt <= match_cnt + 8'd1;
                        if (match_cnt == MATCH_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (slip_cnt == SLIP_LIMIT) begin
                            state  <= FAIL;
                            failed <= 1'b1;
                        end else begin
                            state   <= SLIP;
                            bitslip <= 1'b1;
                        end
                    end
                end
                SLIP: begin
                    slip_cnt <= slip_cnt + 8'd1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // din is still settling after the slip, so it is not compared here
                    if (wait_cnt == WAIT_LAST) begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                    if (train && !hit && (err_cnt != 16'hFFFF)) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end
endmodule
